// File: rtl/ld_pkg.sv
// Shared definitions for the load-return alignment path: func3 encodings,
// the FSM state type and small helpers that decode access size and signedness.
package ld_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ0,
    ST_WAIT0,
    ST_REQ1,
    ST_WAIT1,
    ST_RESP
  } ld_state_e;

  // Access size in bytes; 0 for the never-legal encoding 111.
  function automatic logic [3:0] ld_size(input logic [2:0] func3);
    case (func3)
      F3_LB, F3_LBU: return 4'd1;
      F3_LH, F3_LHU: return 4'd2;
      F3_LW, F3_LWU: return 4'd4;
      F3_LD:         return 4'd8;
      default:       return 4'd0;
    endcase
  endfunction

  // Loads whose result is sign-extended to the register width.
  function automatic logic ld_signed(input logic [2:0] func3);
    return (func3 == F3_LB) || (func3 == F3_LH) || (func3 == F3_LW);
  endfunction

endpackage

// File: rtl/ld_extract.sv
// Byte-aligns the concatenated memory beats and sign/zero-extends the
// selected bytes to the register width. Purely combinational.
module ld_extract
  import ld_pkg::*;
#(
  parameter  int XLEN  = 32,
  localparam int BYTES = XLEN / 8,
  localparam int OFF_W = $clog2(BYTES)
) (
  input  logic [XLEN-1:0]  beat0,
  input  logic [XLEN-1:0]  beat1,
  input  logic [OFF_W-1:0] offset,
  input  logic [2:0]       func3,
  output logic [XLEN-1:0]  data
);

  logic [XLEN-1:0] shifted;
  logic            sgn;

  assign shifted = XLEN'({beat1, beat0} >> {offset, 3'b000});
  assign sgn     = ld_signed(func3);

  // Keep the low size bytes of the shifted window and extend them.
  always_comb begin
    data = '0;
    case (ld_size(func3))
      4'd1: begin
        if (sgn) data = XLEN'($signed(shifted[7:0]));
        else     data = XLEN'(shifted[7:0]);
      end
      4'd2: begin
        if (sgn) data = XLEN'($signed(shifted[15:0]));
        else     data = XLEN'(shifted[15:0]);
      end
      4'd4: begin
        if (sgn) data = XLEN'($signed(shifted[31:0]));
        else     data = XLEN'(shifted[31:0]);
      end
      4'd8:    data = shifted;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/ld_align_unit.sv
// Load-return path: takes one load request, issues one or two word-aligned
// memory reads, merges and formats the data and hands it to writeback.
// Build option LD_MISALIGN_SPLIT_EN: when defined, loads crossing a word
// boundary are split into two reads; otherwise they return a fault.
module ld_align_unit
  import ld_pkg::*;
#(
  parameter  int XLEN  = 32,
  localparam int BYTES = XLEN / 8,
  localparam int OFF_W = $clog2(BYTES)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_func3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [4:0]      req_rd,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [XLEN-1:0] wb_data,
  output logic [4:0]      wb_rd,
  output logic            wb_fault
);

  ld_state_e        state_q, state_d;
  logic [2:0]       func3_q, func3_d;
  logic [OFF_W-1:0] off_q, off_d;
  logic [XLEN-1:0]  waddr_q, waddr_d;
  logic [4:0]       rd_q, rd_d;
  logic [XLEN-1:0]  beat0_q, beat0_d;
  logic             fault_q, fault_d;
  logic [XLEN-1:0]  beat1;
  logic [XLEN-1:0]  ext_data;
  logic             illegal;
  logic             crossing;
`ifdef LD_MISALIGN_SPLIT_EN
  logic [XLEN-1:0]  beat1_q, beat1_d;
  assign beat1 = beat1_q;
`else
  assign beat1 = '0;
`endif

  // Decode of the incoming request, used only when it is accepted.
  assign illegal  = (req_func3 == 3'b111) ||
                    ((XLEN == 32) && ((req_func3 == F3_LD) || (req_func3 == F3_LWU)));
  assign crossing = (int'(req_addr[OFF_W-1:0]) + int'(ld_size(req_func3))) > BYTES;

  ld_extract #(.XLEN(XLEN)) u_extract (
    .beat0  (beat0_q),
    .beat1  (beat1),
    .offset (off_q),
    .func3  (func3_q),
    .data   (ext_data)
  );

  // State register plus captured request fields and memory beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      func3_q <= '0;
      off_q   <= '0;
      waddr_q <= '0;
      rd_q    <= '0;
      beat0_q <= '0;
      fault_q <= 1'b0;
`ifdef LD_MISALIGN_SPLIT_EN
      beat1_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      func3_q <= func3_d;
      off_q   <= off_d;
      waddr_q <= waddr_d;
      rd_q    <= rd_d;
      beat0_q <= beat0_d;
      fault_q <= fault_d;
`ifdef LD_MISALIGN_SPLIT_EN
      beat1_q <= beat1_d;
`endif
    end
  end

  // Next-state logic: sequence the reads and decide the response kind.
  always_comb begin
    state_d = state_q;
    func3_d = func3_q;
    off_d   = off_q;
    waddr_d = waddr_q;
    rd_d    = rd_q;
    beat0_d = beat0_q;
    fault_d = fault_q;
`ifdef LD_MISALIGN_SPLIT_EN
    beat1_d = beat1_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          func3_d = req_func3;
          off_d   = req_addr[OFF_W-1:0];
          waddr_d = {req_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
          rd_d    = req_rd;
          beat0_d = '0;
          fault_d = 1'b0;
`ifdef LD_MISALIGN_SPLIT_EN
          beat1_d = '0;
`endif
          if (illegal) begin
            state_d = ST_RESP;
          end else if (crossing) begin
`ifdef LD_MISALIGN_SPLIT_EN
            state_d = ST_REQ0;
`else
            fault_d = 1'b1;
            state_d = ST_RESP;
`endif
          end else begin
            state_d = ST_REQ0;
          end
        end
      end
      ST_REQ0: begin
        if (mem_req_ready) state_d = ST_WAIT0;
      end
      ST_WAIT0: begin
        if (mem_rsp_valid) begin
          beat0_d = mem_rsp_data;
`ifdef LD_MISALIGN_SPLIT_EN
          if ((int'(off_q) + int'(ld_size(func3_q))) > BYTES) state_d = ST_REQ1;
          else                                                 state_d = ST_RESP;
`else
          state_d = ST_RESP;
`endif
        end
      end
`ifdef LD_MISALIGN_SPLIT_EN
      ST_REQ1: begin
        if (mem_req_ready) state_d = ST_WAIT1;
      end
      ST_WAIT1: begin
        if (mem_rsp_valid) begin
          beat1_d = mem_rsp_data;
          state_d = ST_RESP;
        end
      end
`endif
      ST_RESP: begin
        if (wb_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from registered state so they hold under backpressure.
  always_comb begin
    req_ready     = (state_q == ST_IDLE);
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    wb_valid      = 1'b0;
    wb_data       = '0;
    wb_rd         = '0;
    wb_fault      = 1'b0;
    case (state_q)
      ST_REQ0: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = waddr_q;
      end
`ifdef LD_MISALIGN_SPLIT_EN
      ST_REQ1: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = waddr_q + XLEN'(BYTES);
      end
`endif
      ST_RESP: begin
        wb_valid = 1'b1;
        wb_data  = ext_data;
        wb_rd    = rd_q;
        wb_fault = fault_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ld_align_unit.sv
// Self-checking bench for ld_align_unit. One instance at XLEN=32 and one at
// XLEN=64 share request/data buses; each has its own handshake lines.
module tb_ld_align_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, mem_req_ready, mem_rsp_valid, wb_ready;
  logic [2:0]  req_func3;
  logic [63:0] req_addr;
  logic [4:0]  req_rd;
  logic [63:0] mem_rsp_data;

  logic        req_ready [2];
  logic        mem_req_valid [2];
  logic        wb_valid [2];
  logic        wb_fault [2];
  logic [4:0]  wb_rd [2];
  logic [63:0] mem_req_addr [2];
  logic [63:0] wb_data [2];
  logic [31:0] mra32, wbd32;

  int n_compared   = 0;
  int n_mismatched = 0;
  int cyc          = 0;

  // Free-running clock and a cycle counter used for latency checks.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ld_align_unit #(.XLEN(32)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_func3(req_func3), .req_addr(req_addr[31:0]), .req_rd(req_rd),
    .mem_req_valid(mem_req_valid[0]), .mem_req_ready(mem_req_ready[0]),
    .mem_req_addr(mra32),
    .mem_rsp_valid(mem_rsp_valid[0]), .mem_rsp_data(mem_rsp_data[31:0]),
    .wb_valid(wb_valid[0]), .wb_ready(wb_ready[0]), .wb_data(wbd32),
    .wb_rd(wb_rd[0]), .wb_fault(wb_fault[0])
  );
  assign mem_req_addr[0] = {32'h0, mra32};
  assign wb_data[0]      = {32'h0, wbd32};

  ld_align_unit #(.XLEN(64)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_func3(req_func3), .req_addr(req_addr), .req_rd(req_rd),
    .mem_req_valid(mem_req_valid[1]), .mem_req_ready(mem_req_ready[1]),
    .mem_req_addr(mem_req_addr[1]),
    .mem_rsp_valid(mem_rsp_valid[1]), .mem_rsp_data(mem_rsp_data),
    .wb_valid(wb_valid[1]), .wb_ready(wb_ready[1]), .wb_data(wb_data[1]),
    .wb_rd(wb_rd[1]), .wb_fault(wb_fault[1])
  );

  // Reference: gather bytes from the two beats, pick size bytes at the offset,
  // extend arithmetically. Also reports how many memory reads are expected.
  function automatic void ref_model(input int w, input logic [2:0] f3, input int off,
                                    input logic [63:0] b0, input logic [63:0] b1,
                                    output logic [63:0] data, output bit fault,
                                    output int nreq);
    logic [7:0] bytes_a [16];
    int nb, size;
    bit sgn, illegal;
    nb = (w != 0) ? 8 : 4;
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2, 3'd6: size = 4;
      3'd3:       size = 8;
      default:    size = 0;
    endcase
    sgn     = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    illegal = (f3 == 3'd7) || ((w == 0) && ((f3 == 3'd3) || (f3 == 3'd6)));
    data  = '0;
    fault = 1'b0;
    nreq  = 0;
    if (illegal) return;
    if (off + size > nb) begin
`ifdef LD_MISALIGN_SPLIT_EN
      nreq = 2;
`else
      fault = 1'b1;
      return;
`endif
    end else begin
      nreq = 1;
    end
    for (int i = 0; i < nb; i++) begin
      bytes_a[i]      = b0[8*i +: 8];
      bytes_a[nb + i] = b1[8*i +: 8];
    end
    for (int i = 0; i < size; i++) data[8*i +: 8] = bytes_a[off + i];
    if (sgn && data[8*size-1])
      for (int i = size; i < 8; i++) data[8*i +: 8] = 8'hFF;
    if (w == 0) data[63:32] = '0;
  endfunction

  // One comparison: counted, and reported on mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run one load on instance w, acting as memory and writeback, with optional
  // stalls on the memory request, the response, and the writeback side.
  task automatic applyStimulus(input int w, input logic [2:0] f3, input logic [63:0] addr,
                               input logic [4:0] rd, input logic [63:0] b0, input logic [63:0] b1,
                               input int mstall, input int rdelay, input int wstall,
                               input bit chk_lat);
    logic [63:0] exp_data, base, a_mask, hold;
    bit exp_fault, got;
    int exp_nreq, nb, off, start, budget, exp_lat;
    nb     = (w != 0) ? 8 : 4;
    a_mask = (w != 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    addr   = addr & a_mask;
    off    = int'(addr[2:0]) % nb;
    base   = addr - 64'(off);
    ref_model(w, f3, off, b0, b1, exp_data, exp_fault, exp_nreq);
    exp_lat = (exp_nreq == 0) ? 1 : ((exp_nreq == 1) ? 3 : 5);

    checkOutput("req_ready_idle", 64'(req_ready[w]), 64'd1);
    req_func3    = f3;
    req_addr     = addr;
    req_rd       = rd;
    req_valid[w] = 1'b1;
    start        = cyc;
    step();
    req_valid[w] = 1'b0;

    for (int k = 0; k < exp_nreq; k++) begin
      budget = 0;
      while (!mem_req_valid[w] && budget < 20) begin
        step();
        budget++;
      end
      got = mem_req_valid[w];
      checkOutput("mem_req_seen", 64'(got), 64'd1);
      if (!got) return;
      hold = mem_req_addr[w];
      checkOutput("mem_req_addr", hold, (base + 64'(k * nb)) & a_mask);
      repeat (mstall) step();
      if (mstall > 0) begin
        checkOutput("mem_req_hold_valid", 64'(mem_req_valid[w]), 64'd1);
        checkOutput("mem_req_hold_addr", mem_req_addr[w], hold);
      end
      mem_req_ready[w] = 1'b1;
      step();
      mem_req_ready[w] = 1'b0;
      repeat (rdelay) step();
      mem_rsp_data     = (k != 0) ? b1 : b0;
      mem_rsp_valid[w] = 1'b1;
      step();
      mem_rsp_valid[w] = 1'b0;
    end

    budget = 0;
    while (!wb_valid[w] && budget < 20) begin
      step();
      budget++;
    end
    got = wb_valid[w];
    checkOutput("wb_valid_seen", 64'(got), 64'd1);
    if (!got) return;
    checkOutput("no_extra_mem_req", 64'(mem_req_valid[w]), 64'd0);
    if (chk_lat && mstall == 0 && rdelay == 0)
      checkOutput("latency", 64'(cyc - start), 64'(exp_lat));
    checkOutput("wb_data", wb_data[w], exp_data);
    checkOutput("wb_fault", 64'(wb_fault[w]), 64'(exp_fault));
    checkOutput("wb_rd", 64'(wb_rd[w]), 64'(rd));
    hold = wb_data[w];
    repeat (wstall) step();
    if (wstall > 0) begin
      checkOutput("wb_hold_valid", 64'(wb_valid[w]), 64'd1);
      checkOutput("wb_hold_data", wb_data[w], hold);
      checkOutput("wb_hold_req_ready", 64'(req_ready[w]), 64'd0);
    end
    wb_ready[w] = 1'b1;
    step();
    wb_ready[w] = 1'b0;
    checkOutput("wb_released", 64'(wb_valid[w]), 64'd0);
    checkOutput("req_ready_after", 64'(req_ready[w]), 64'd1);
  endtask

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed plan followed by randomized loads on both widths.
  initial begin
    int budget;
    rst_n         = 1'b0;
    req_valid     = '0;
    mem_req_ready = '0;
    mem_rsp_valid = '0;
    wb_ready      = '0;
    req_func3     = '0;
    req_addr      = '0;
    req_rd        = '0;
    mem_rsp_data  = '0;
    #12;
    for (int w = 0; w < 2; w++) begin
      checkOutput("reset_req_ready", 64'(req_ready[w]), 64'd1);
      checkOutput("reset_mem_req_valid", 64'(mem_req_valid[w]), 64'd0);
      checkOutput("reset_wb_valid", 64'(wb_valid[w]), 64'd0);
      checkOutput("reset_wb_data", wb_data[w], 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Byte / halfword sign and zero extension at XLEN=32.
    applyStimulus(0, 3'b000, 64'h1003, 5'd1, 64'h80FF1234, 64'h0, 0, 0, 0, 1'b1);
    applyStimulus(0, 3'b101, 64'h1002, 5'd2, 64'hBEEF0000, 64'h0, 0, 0, 0, 1'b1);
    applyStimulus(0, 3'b001, 64'h1002, 5'd3, 64'hBEEF0000, 64'h0, 0, 1, 0, 1'b0);
    applyStimulus(0, 3'b001, 64'h1001, 5'd4, 64'h00ABCD00, 64'h0, 0, 0, 0, 1'b1);
    // Word crossing a boundary: split or fault depending on the build.
    applyStimulus(0, 3'b010, 64'h1003, 5'd5, 64'hAABBCCDD, 64'h11223344, 0, 0, 0, 1'b1);
    applyStimulus(0, 3'b010, 64'hFFFF_FFFE, 5'd6, 64'h12345678, 64'h9ABCDEF0, 0, 0, 0, 1'b1);
    // XLEN=64 word loads, signed and unsigned.
    applyStimulus(1, 3'b110, 64'h2004, 5'd7, 64'h80000001_00000000, 64'h0, 0, 0, 0, 1'b1);
    applyStimulus(1, 3'b010, 64'h2004, 5'd8, 64'h80000001_00000000, 64'h0, 0, 0, 0, 1'b1);
    applyStimulus(1, 3'b011, 64'h3000, 5'd9, 64'hFEDCBA98_76543210, 64'h0, 0, 0, 0, 1'b1);
    applyStimulus(1, 3'b011, 64'h3005, 5'd10, 64'hFEDCBA98_76543210, 64'h01234567_89ABCDEF, 0, 0, 0, 1'b1);
    // Backpressure on both the memory request and writeback.
    applyStimulus(0, 3'b010, 64'h4000, 5'd11, 64'hCAFEF00D, 64'h0, 4, 0, 3, 1'b0);
    applyStimulus(1, 3'b100, 64'h4007, 5'd12, 64'h9100_0000_0000_0000, 64'h0, 4, 2, 3, 1'b0);
    // Illegal encodings: immediate zero response with no memory traffic.
    applyStimulus(0, 3'b011, 64'h5000, 5'd13, 64'h0, 64'h0, 0, 0, 0, 1'b1);
    applyStimulus(0, 3'b110, 64'h5000, 5'd14, 64'h0, 64'h0, 0, 0, 0, 1'b1);
    applyStimulus(1, 3'b111, 64'h5000, 5'd15, 64'h0, 64'h0, 0, 0, 0, 1'b1);

    // Reset while waiting on the last read; a late response must be ignored.
    req_func3    = 3'b010;
`ifdef LD_MISALIGN_SPLIT_EN
    req_addr     = 64'h6003;
`else
    req_addr     = 64'h6000;
`endif
    req_rd       = 5'd16;
    req_valid[0] = 1'b1;
    step();
    req_valid[0] = 1'b0;
    budget = 0;
    while (!mem_req_valid[0] && budget < 20) begin step(); budget++; end
    mem_req_ready[0] = 1'b1;
    step();
    mem_req_ready[0] = 1'b0;
`ifdef LD_MISALIGN_SPLIT_EN
    mem_rsp_data     = 64'h11111111;
    mem_rsp_valid[0] = 1'b1;
    step();
    mem_rsp_valid[0] = 1'b0;
    budget = 0;
    while (!mem_req_valid[0] && budget < 20) begin step(); budget++; end
    mem_req_ready[0] = 1'b1;
    step();
    mem_req_ready[0] = 1'b0;
`endif
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_req_ready", 64'(req_ready[0]), 64'd1);
    checkOutput("async_rst_mem_req_valid", 64'(mem_req_valid[0]), 64'd0);
    checkOutput("async_rst_mem_req_addr", mem_req_addr[0], 64'd0);
    checkOutput("async_rst_wb_valid", 64'(wb_valid[0]), 64'd0);
    checkOutput("async_rst_wb_data", wb_data[0], 64'd0);
    checkOutput("async_rst_wb_rd", 64'(wb_rd[0]), 64'd0);
    step();
    rst_n            = 1'b1;
    mem_rsp_data     = 64'h22222222;
    mem_rsp_valid[0] = 1'b1;
    step();
    mem_rsp_valid[0] = 1'b0;
    step();
    checkOutput("late_rsp_wb_valid", 64'(wb_valid[0]), 64'd0);
    checkOutput("late_rsp_mem_req_valid", 64'(mem_req_valid[0]), 64'd0);
    checkOutput("late_rsp_req_ready", 64'(req_ready[0]), 64'd1);

    // Randomized loads across both widths, all func3 codes and offsets.
    for (int n = 0; n < 80; n++) begin
      int w, ms, rdl, ws;
      logic [2:0]  f3;
      logic [63:0] a, b0, b1;
      w   = int'($urandom_range(0, 1));
      f3  = 3'($urandom_range(0, 7));
      a   = {$urandom, $urandom};
      b0  = {$urandom, $urandom};
      b1  = {$urandom, $urandom};
      if (w == 0) begin
        b0[63:32] = '0;
        b1[63:32] = '0;
      end
      ms  = int'($urandom_range(0, 2));
      rdl = int'($urandom_range(0, 2));
      ws  = int'($urandom_range(0, 2));
      applyStimulus(w, f3, a, 5'($urandom_range(0, 31)), b0, b1, ms, rdl, ws, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/ld_align_unit.md
Name: ld_align_unit

Overview:
- Sequential load-return path between the LSU address stage and register writeback.
- Accepts one load request (func3 plus full byte address) and issues one or two word-aligned memory reads.
- Merges the returned beats, byte-aligns the result, then sign- or zero-extends to XLEN.
- Parametrised successor of the combinational load filter: XLEN 32/64, LD/LWU support, misaligned loads that cross a word boundary, and valid/ready handshakes on all sides.

Parameters:
- XLEN, 32, data/address width; legal values 32 or 64.
- BYTES, XLEN/8, bytes per memory word; derived, not overridable.
- OFF_W, $clog2(BYTES), width of the byte-offset field.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  load request valid.
- req_ready  out  1  unit can accept a request.
- req_func3  in  3  000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU.
- req_addr  in  XLEN  byte address.
- req_rd  in  5  destination register tag.
- mem_req_valid  out  1  memory read request.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_addr  out  XLEN  word-aligned address (low OFF_W bits zero).
- mem_rsp_valid  in  1  read data valid; responses are in order, one outstanding.
- mem_rsp_data  in  XLEN  read data.
- wb_valid  out  1  result valid.
- wb_ready  in  1  writeback accepts the result.
- wb_data  out  XLEN  formatted load data.
- wb_rd  out  5  destination tag.
- wb_fault  out  1  misaligned-crossing fault; qualified by wb_valid.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE; all outputs go to 0 except req_ready=1.
  - Captured beats, func3, offset and rd registers clear.
  - Any mem_rsp_valid arriving after reset while in IDLE is ignored.
- Size: LB/LBU=1, LH/LHU=2, LW/LWU=4, LD=8 bytes.
  - When XLEN=32, LD and LWU are illegal; func3 111 is always illegal.
- Crossing: a load crosses when offset + size > BYTES.
- States:
  - IDLE:
    - req_ready=1. On req_valid, latch func3, offset=addr[OFF_W-1:0], word address and rd.
    - Illegal func3: go to RESP with data 0 and fault 0, no memory access.
    - Otherwise go to REQ0.
  - REQ0:
    - mem_req_valid=1, mem_req_addr = word address.
    - On mem_req_ready, go to WAIT0.
  - WAIT0:
    - On mem_rsp_valid, capture beat0.
    - If crossing, go to REQ1; otherwise go to RESP.
  - REQ1:
    - mem_req_valid=1, mem_req_addr = word address + BYTES (wraps modulo 2^XLEN).
    - On mem_req_ready, go to WAIT1.
  - WAIT1: on mem_rsp_valid, capture beat1 and go to RESP.
  - RESP:
    - wb_valid=1; wb_data, wb_rd and wb_fault are registered and held stable until wb_ready.
    - On wb_ready, go to IDLE. No new request is accepted in the same cycle.
- Extraction:
  - Form {beat1, beat0} (2*XLEN bits) and shift right by offset*8.
  - Take the low size bytes; sign-extend for LB/LH/LW(64), zero-extend for LBU/LHU/LWU.
  - LW at XLEN=32 and LD pass through unextended.
- Latency:
  - Aligned load with zero-wait memory: request accepted at cycle 0, mem_req_valid at cycle 1, rsp earliest cycle 2, wb_valid at cycle 3.
  - A crossing load adds 2 cycles.
- Backpressure:
  - mem_req_valid, once asserted, stays asserted with a stable address until mem_req_ready.
  - wb outputs stay stable until wb_ready.
- mem_rsp_valid outside WAIT0/WAIT1 is ignored.

Optional Feature:
- Macro: LD_MISALIGN_SPLIT_EN.
- Defined: crossing loads use REQ1/WAIT1 as described above.
- Undefined:
  - A crossing load goes IDLE to RESP with wb_fault=1, wb_data=0, and no memory request.
  - REQ1/WAIT1 and the beat1 register are not synthesised; beat1 is treated as 0.
  - Non-crossing misaligned loads (e.g. LB at any offset, LH at offset 1 when XLEN=32) still complete normally.

Decomposition:
- Package ld_pkg:
  - func3 localparams/enum.
  - State enum (IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP).
  - Function ld_size(func3) returning bytes.
  - Function ld_signed(func3).
- Sub-module ld_extract: combinational shift, select and extend from {beat1, beat0}, offset and func3 to XLEN data.
- ld_align_unit holds the FSM, handshakes and registers.

Test Plan:
- XLEN=32, LB at 0x1003, beat0=0x80FF1234 -> wb_data=0xFFFFFF80, wb_fault=0, one memory request to 0x1000.
- LHU at 0x1002, beat0=0xBEEF0000 -> wb_data=0x0000BEEF; LH with the same data -> 0xFFFFBEEF.
- LW at 0x1003 with SPLIT_EN, beat0(0x1000)=0xAABBCCDD, beat1(0x1004)=0x11223344 -> wb_data=0x223344AA, two memory requests. Without the macro -> wb_fault=1, wb_data=0, no mem_req_valid.
- XLEN=64, LWU at 0x...4 with beat0=0x80000001_00000000 -> 0x0000000080000001; LW with the same data -> 0xFFFFFFFF80000001.
- Backpressure:
  - Hold mem_req_ready=0 for 4 cycles -> mem_req_addr stays stable.
  - Hold wb_ready=0 for 3 cycles -> wb_data stays stable and req_ready=0.
- Reset and illegal func3:
  - Assert rst_n=0 in WAIT1 -> IDLE, outputs 0, req_ready=1; a late mem_rsp_valid is ignored.
  - func3=011 at XLEN=32 -> wb_data=0 after 1 cycle, no memory access.
